// File: rtl/pe_command_sequencer_pkg.sv
// Shared definitions for the PE command sequencer: PE command codes, schedule
// phases, FSM states and the phase-to-command mapping.
package pe_command_sequencer_pkg;

  localparam int unsigned CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_MUL    = 3'b000;
  localparam logic [CMD_W-1:0] CMD_UP     = 3'b001;
  localparam logic [CMD_W-1:0] CMD_DOWN   = 3'b010;
  localparam logic [CMD_W-1:0] CMD_LEFT   = 3'b011;
  localparam logic [CMD_W-1:0] CMD_RIGHT  = 3'b100;
  localparam logic [CMD_W-1:0] CMD_OVR_AB = 3'b101;
  localparam logic [CMD_W-1:0] CMD_OVR_S  = 3'b110;
  localparam logic [CMD_W-1:0] CMD_RST    = 3'b111;

  typedef enum logic [1:0] {
    PH_RST,
    PH_MUL,
    PH_SA,
    PH_SB
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_READY,
    ST_RELEASE,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Command code issued for a given schedule phase and latched shift directions.
  function automatic logic [CMD_W-1:0] phase_cmd(input phase_e ph, input logic a_dir_down,
                                                 input logic b_dir_right);
    logic [CMD_W-1:0] cmd;
    case (ph)
      PH_MUL:  cmd = CMD_MUL;
      PH_SA:   cmd = a_dir_down ? CMD_DOWN : CMD_UP;
      PH_SB:   cmd = b_dir_right ? CMD_RIGHT : CMD_LEFT;
      default: cmd = CMD_RST;
    endcase
    return cmd;
  endfunction

  // Overwrite commands exist on the PE but are never produced by the sequencer.
  function automatic logic is_overwrite_cmd(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_OVR_AB) || (cmd == CMD_OVR_S);
  endfunction

endpackage

// File: rtl/pe_handshake_timer.sv
// Per-command handshake watchdog: counts cycles while enabled and flags when
// the count reaches TIMEOUT.
module pe_handshake_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TMO_W   = 8
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_c_o
);

  logic [TMO_W-1:0] count_q;
  logic [TMO_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TMO_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_c_o = (count_q == TMO_W'(TIMEOUT));

endmodule

// File: rtl/pe_command_sequencer.sv
// Drives the PE array command handshake through a reset / (multiply, shift A,
// shift B) x num_steps schedule, with a per-command stall timeout.
module pe_command_sequencer
  import pe_command_sequencer_pkg::*;
#(
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TMO_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              go,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              a_dir_down,
  input  logic              b_dir_right,
  input  logic              pe_ready,
  output logic              start,
  output logic              ack,
  output logic [CMD_W-1:0]  command_to_execute,
  output logic              image_to_shift,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [STEP_W-1:0] step_count
);

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              a_dir_q, a_dir_d;
  logic              b_dir_q, b_dir_d;
  logic              start_q, start_d;
  logic              ack_q, ack_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              img_q, img_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              tmr_clr, tmr_en, tmr_expired;

  pe_handshake_timer #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_timer (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .clr_i       (tmr_clr),
    .en_i        (tmr_en),
    .expired_c_o (tmr_expired)
  );

  // Next-state, schedule bookkeeping and registered-output lookahead.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    steps_d    = steps_q;
    step_cnt_d = step_cnt_q;
    a_dir_d    = a_dir_q;
    b_dir_d    = b_dir_q;
    err_d      = err_q;
    cmd_d      = cmd_q;
    img_d      = img_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          steps_d    = num_steps;
          a_dir_d    = a_dir_down;
          b_dir_d    = b_dir_right;
          err_d      = 1'b0;
          step_cnt_d = '0;
          phase_d    = PH_RST;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_READY;
      ST_WAIT_READY: begin
        if (pe_ready) begin
          state_d = ST_RELEASE;
        end else if (tmr_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_RELEASE: begin
        if (!pe_ready) begin
          state_d = ST_NEXT;
        end else if (tmr_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_NEXT: begin
        case (phase_q)
          PH_RST: begin
            if (steps_q != '0) begin
              phase_d = PH_MUL;
              state_d = ST_ISSUE;
            end else begin
              state_d = ST_DONE;
            end
          end
          PH_MUL: begin
            phase_d = PH_SA;
            state_d = ST_ISSUE;
          end
          PH_SA: begin
            phase_d = PH_SB;
            state_d = ST_ISSUE;
          end
          default: begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
            if (step_cnt_d == steps_q) begin
              state_d = ST_DONE;
            end else begin
              phase_d = PH_MUL;
              state_d = ST_ISSUE;
            end
          end
        endcase
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (state_d == ST_ERROR) begin
      err_d = 1'b1;
    end

    // Timer restarts at each command issue and again when the ready edge is seen.
    tmr_clr = (state_d == ST_ISSUE) || ((state_q == ST_WAIT_READY) && (state_d == ST_RELEASE));
    tmr_en  = (state_q == ST_ISSUE) || (state_q == ST_WAIT_READY) || (state_q == ST_RELEASE);

    start_d = (state_d == ST_ISSUE);
    ack_d   = !((state_d == ST_ISSUE) || (state_d == ST_WAIT_READY));
    busy_d  = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERROR));
    done_d  = (state_d == ST_DONE);

    if (state_d == ST_ISSUE) begin
      cmd_d = phase_cmd(phase_d, a_dir_d, b_dir_d);
      img_d = (phase_d == PH_SB);
    end else if (!busy_d) begin
      img_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_RST;
      steps_q    <= '0;
      step_cnt_q <= '0;
      a_dir_q    <= 1'b0;
      b_dir_q    <= 1'b0;
      start_q    <= 1'b0;
      ack_q      <= 1'b1;
      cmd_q      <= CMD_MUL;
      img_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      steps_q    <= steps_d;
      step_cnt_q <= step_cnt_d;
      a_dir_q    <= a_dir_d;
      b_dir_q    <= b_dir_d;
      start_q    <= start_d;
      ack_q      <= ack_d;
      cmd_q      <= cmd_d;
      img_q      <= img_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign start              = start_q;
  assign ack                = ack_q;
  assign command_to_execute = cmd_q;
  assign image_to_shift     = img_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign step_count         = step_cnt_q;

endmodule

// File: tb/tb_pe_command_sequencer.sv
// Self-checking bench for pe_command_sequencer: behavioural PE, command monitor
// and a schedule-level reference model.
module tb_pe_command_sequencer;

  localparam int unsigned STEP_W = 8;
  localparam int unsigned TMO    = 255;

  localparam int PE_NORMAL = 0;
  localparam int PE_STUCK  = 1;
  localparam int PE_EARLY  = 2;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              go;
  logic [STEP_W-1:0] num_steps;
  logic              a_dir_down;
  logic              b_dir_right;
  logic              pe_ready;
  logic              start;
  logic              ack;
  logic [2:0]        command_to_execute;
  logic              image_to_shift;
  logic              busy;
  logic              done;
  logic              err;
  logic [STEP_W-1:0] step_count;

  int n_checks = 0;
  int n_fail   = 0;

  int pe_mode = PE_NORMAL;
  int rdy_lat = 3;
  int rel_lat = 1;
  int pe_st   = 0;
  int pe_cnt  = 0;

  logic [2:0] mon_cmd[$];
  logic       mon_img[$];
  logic [2:0] exp_cmd[$];
  logic       exp_img[$];
  int         done_cnt  = 0;
  int         ack_falls = 0;
  int         ack_rises = 0;
  logic       prev_ack  = 1'b1;

  pe_command_sequencer #(
    .STEP_W  (STEP_W),
    .TIMEOUT (TMO),
    .TMO_W   (8)
  ) dut (
    .CLK                (CLK),
    .RESET_N            (RESET_N),
    .go                 (go),
    .num_steps          (num_steps),
    .a_dir_down         (a_dir_down),
    .b_dir_right        (b_dir_right),
    .pe_ready           (pe_ready),
    .start              (start),
    .ack                (ack),
    .command_to_execute (command_to_execute),
    .image_to_shift     (image_to_shift),
    .busy               (busy),
    .done               (done),
    .err                (err),
    .step_count         (step_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Schedule-level reference: RST, then (MUL, shift A, shift B) per step.
  function automatic void build_expected(input int ns, input bit a, input bit b);
    exp_cmd.delete();
    exp_img.delete();
    exp_cmd.push_back(3'b111); exp_img.push_back(1'b0);
    for (int i = 0; i < ns; i++) begin
      exp_cmd.push_back(3'b000);                  exp_img.push_back(1'b0);
      exp_cmd.push_back(a ? 3'b010 : 3'b001);     exp_img.push_back(1'b0);
      exp_cmd.push_back(b ? 3'b100 : 3'b011);     exp_img.push_back(1'b1);
    end
  endfunction

  // Behavioural PE: raises ready rdy_lat cycles after start, drops it rel_lat after ack.
  initial begin
    pe_ready = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        pe_st    = 0;
        pe_ready = 1'b0;
      end else begin
        case (pe_st)
          0: begin
            if (pe_mode == PE_EARLY) pe_ready = 1'b1;
            if (start && pe_mode == PE_EARLY) begin
              pe_st = 2;
            end else if (start && pe_mode == PE_NORMAL) begin
              if (rdy_lat == 0) begin
                pe_ready = 1'b1;
                pe_st    = 2;
              end else begin
                pe_cnt = rdy_lat;
                pe_st  = 1;
              end
            end
          end
          1: begin
            pe_cnt--;
            if (pe_cnt == 0) begin
              pe_ready = 1'b1;
              pe_st    = 2;
            end
          end
          2: begin
            if (ack) begin
              if (rel_lat == 0 || pe_mode == PE_EARLY) begin
                pe_ready = 1'b0;
                pe_st    = 0;
              end else begin
                pe_cnt = rel_lat;
                pe_st  = 3;
              end
            end
          end
          default: begin
            pe_cnt--;
            if (pe_cnt == 0) begin
              pe_ready = 1'b0;
              pe_st    = 0;
            end
          end
        endcase
      end
    end
  end

  // Monitor: records issued commands, done pulses and ack edges.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET_N) begin
        if (start) begin
          mon_cmd.push_back(command_to_execute);
          mon_img.push_back(image_to_shift);
        end
        if (done) done_cnt++;
        if (prev_ack && !ack) ack_falls++;
        if (!prev_ack && ack) ack_rises++;
      end
      prev_ack = ack;
    end
  end

  task automatic clear_monitor();
    mon_cmd.delete();
    mon_img.delete();
    done_cnt  = 0;
    ack_falls = 0;
    ack_rises = 0;
  endtask

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_start"}, 32'(start), 32'd0);
    check_eq({pfx, "_ack"},   32'(ack), 32'd1);
    check_eq({pfx, "_cmd"},   32'(command_to_execute), 32'd0);
    check_eq({pfx, "_img"},   32'(image_to_shift), 32'd0);
    check_eq({pfx, "_busy"},  32'(busy), 32'd0);
    check_eq({pfx, "_done"},  32'(done), 32'd0);
    check_eq({pfx, "_err"},   32'(err), 32'd0);
    check_eq({pfx, "_steps"}, 32'(step_count), 32'd0);
  endtask

  // Runs one schedule to completion and compares it against the reference model.
  task automatic run_and_check(input string tag, input int ns, input bit a, input bit b,
                               input bit spam_go);
    int n;
    int ncmp;
    build_expected(ns, a, b);
    @(negedge CLK);
    clear_monitor();
    num_steps   = STEP_W'(ns);
    a_dir_down  = a;
    b_dir_right = b;
    go          = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    check_eq({tag, "_err_clr"}, 32'(err), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 3000) begin
      if (spam_go) begin
        go          = 1'($urandom_range(0, 1));
        num_steps   = STEP_W'($urandom_range(0, 255));
        a_dir_down  = 1'($urandom_range(0, 1));
        b_dir_right = 1'($urandom_range(0, 1));
      end
      @(negedge CLK);
      n++;
    end
    go = 1'b0;
    check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
    repeat (2) @(negedge CLK);
    check_eq({tag, "_ncmd"}, 32'(mon_cmd.size()), 32'(exp_cmd.size()));
    ncmp = (mon_cmd.size() < exp_cmd.size()) ? mon_cmd.size() : exp_cmd.size();
    for (int i = 0; i < ncmp; i++) begin
      check_eq($sformatf("%s_cmd%0d", tag, i), 32'(mon_cmd[i]), 32'(exp_cmd[i]));
      check_eq($sformatf("%s_img%0d", tag, i), 32'(mon_img[i]), 32'(exp_img[i]));
    end
    check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_step_count"}, 32'(step_count), 32'(ns));
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_ack_falls"}, 32'(ack_falls), 32'(exp_cmd.size()));
    check_eq({tag, "_ack_rises"}, 32'(ack_rises), 32'(exp_cmd.size()));
  endtask

  initial begin
    int n;
    RESET_N     = 1'b0;
    go          = 1'b0;
    num_steps   = '0;
    a_dir_down  = 1'b0;
    b_dir_right = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_values("rst");
    RESET_N = 1'b1;
    @(negedge CLK);

    // Directed schedules: two steps, then zero steps.
    rdy_lat = 3; rel_lat = 1;
    run_and_check("t1", 2, 1'b0, 1'b1, 1'b0);
    run_and_check("t2", 0, 1'b1, 1'b0, 1'b0);

    // Stalled PE: timeout after 256 cycles, sticky err, no further start.
    pe_mode = PE_STUCK;
    @(negedge CLK);
    clear_monitor();
    num_steps = STEP_W'(3);
    go        = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    check_eq("tmo_start", 32'(start), 32'd1);
    n = 0;
    while (err !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check_eq("tmo_cycles", 32'(n), 32'd256);
    check_eq("tmo_busy", 32'(busy), 32'd0);
    check_eq("tmo_ack", 32'(ack), 32'd1);
    repeat (20) @(negedge CLK);
    check_eq("tmo_nstart", 32'(mon_cmd.size()), 32'd1);
    check_eq("tmo_err_sticky", 32'(err), 32'd1);
    check_eq("tmo_no_done", 32'(done_cnt), 32'd0);

    // Recovery after timeout: err clears on go.
    pe_mode = PE_NORMAL;
    run_and_check("t6", 1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while waiting for ready on the first MUL.
    rdy_lat = 6; rel_lat = 1;
    @(negedge CLK);
    clear_monitor();
    num_steps = STEP_W'(3);
    go        = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    n = 0;
    while (mon_cmd.size() < 2 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check_eq("arst_reached_mul", 32'(command_to_execute), 32'd0);
    @(negedge CLK);
    check_eq("arst_wait_ack", 32'(ack), 32'd0);
    #2 RESET_N = 1'b0;
    #1 check_reset_values("arst");
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    rdy_lat = 3;
    run_and_check("t4", 2, 1'b1, 1'b1, 1'b0);

    // Ready held high across ISSUE while go is hammered during the schedule.
    pe_mode = PE_EARLY;
    run_and_check("t5", 3, 1'b1, 1'b0, 1'b1);
    pe_mode = PE_NORMAL;
    repeat (3) @(negedge CLK);

    // Randomised schedules and PE latencies.
    for (int it = 0; it < 8; it++) begin
      rdy_lat = $urandom_range(0, 6);
      rel_lat = $urandom_range(0, 3);
      run_and_check($sformatf("rnd%0d", it), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
